// File: rtl/pwm_capture.sv
// pwm_capture: measures an asynchronous PWM input and reports its high time, period and
// 8-bit duty, floor(high_time * 256 / period), on the same 0..255 scale as the PWM generators.
//
// Ports:
//   clk        system clock
//   rst        synchronous active-high reset
//   enable     measurement enable; low returns to idle and clears measurement state
//   pwm_in     asynchronous PWM input
//   high_time  last measured high time in clk cycles
//   period     last measured period in clk cycles
//   duty       8-bit duty; 255 when stuck high, 0 when stuck low
//   valid      one-cycle pulse when duty/high_time/period update
//   busy       high while the divider runs
//   stuck_high line held high for TIMEOUT cycles
//   stuck_low  line held low for TIMEOUT cycles
//   overrun    sticky; a period completed while the divider was busy
//
// TIMEOUT must lie in 10 .. 2^CNT_W-1.
module pwm_capture #(
  parameter int unsigned CNT_W   = 16,
  parameter int unsigned TIMEOUT = 65535
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             enable,
  input  logic             pwm_in,
  output logic [CNT_W-1:0] high_time,
  output logic [CNT_W-1:0] period,
  output logic [7:0]       duty,
  output logic             valid,
  output logic             busy,
  output logic             stuck_high,
  output logic             stuck_low,
  output logic             overrun
);

  localparam logic [CNT_W-1:0] TimeoutCnt = CNT_W'(TIMEOUT);
  localparam logic [CNT_W-1:0] CntOne     = CNT_W'(1);

  typedef enum logic [1:0] {StIdle, StWaitRise, StMeasure, StDivide} state_e;

  state_e           state_q;
  logic             sync1_q, s_q, s_d_q;
  logic [CNT_W-1:0] per_cnt_q, high_cnt_q;
  logic [CNT_W-1:0] high_time_q, period_q;
  logic [CNT_W:0]   rem_q;
  logic [7:0]       quo_q, duty_q;
  logic [2:0]       step_q;
  logic             valid_q, busy_q, stuck_high_q, stuck_low_q, overrun_q;

  logic             rise, at_timeout, quo_bit;
  logic [CNT_W-1:0] per_cnt_d, high_cnt_d;
  logic [CNT_W:0]   rem_shift, rem_d;
  logic [7:0]       quo_d;

  always_comb begin
    rise       = s_q & ~s_d_q;
    at_timeout = (per_cnt_q == TimeoutCnt);
    // Both counters saturate at TIMEOUT.
    per_cnt_d  = at_timeout ? per_cnt_q : per_cnt_q + CntOne;
    high_cnt_d = high_cnt_q;
    if (s_q && (high_cnt_q != TimeoutCnt)) begin
      high_cnt_d = high_cnt_q + CntOne;
    end
    // One restoring-division step; the remainder stays below period so 2r fits CNT_W+1 bits.
    rem_shift = {rem_q[CNT_W-1:0], 1'b0};
    quo_bit   = (rem_shift >= {1'b0, period_q});
    rem_d     = quo_bit ? (rem_shift - {1'b0, period_q}) : rem_shift;
    quo_d     = {quo_q[6:0], quo_bit};
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= StIdle;
      sync1_q      <= 1'b0;
      s_q          <= 1'b0;
      s_d_q        <= 1'b0;
      per_cnt_q    <= '0;
      high_cnt_q   <= '0;
      high_time_q  <= '0;
      period_q     <= '0;
      rem_q        <= '0;
      quo_q        <= '0;
      step_q       <= '0;
      duty_q       <= '0;
      valid_q      <= 1'b0;
      busy_q       <= 1'b0;
      stuck_high_q <= 1'b0;
      stuck_low_q  <= 1'b0;
      overrun_q    <= 1'b0;
    end else begin
      sync1_q <= pwm_in;
      s_q     <= sync1_q;
      s_d_q   <= s_q;
      valid_q <= 1'b0;
      if (!enable) begin
        // Aborts any in-flight divide without a valid pulse; results and overrun hold.
        state_q      <= StIdle;
        per_cnt_q    <= '0;
        high_cnt_q   <= '0;
        busy_q       <= 1'b0;
        stuck_high_q <= 1'b0;
        stuck_low_q  <= 1'b0;
      end else begin
        unique case (state_q)
          StIdle: begin
            per_cnt_q  <= '0;
            high_cnt_q <= '0;
            state_q    <= StWaitRise;
          end
          StWaitRise: begin
            if (rise) begin
              per_cnt_q    <= CntOne;
              high_cnt_q   <= CntOne;
              stuck_high_q <= 1'b0;
              stuck_low_q  <= 1'b0;
              state_q      <= StMeasure;
            end else begin
              per_cnt_q <= per_cnt_d;
              // Report a stuck line once; the flags block a repeat until the next edge.
              if (at_timeout && !stuck_high_q && !stuck_low_q) begin
                stuck_high_q <= s_q;
                stuck_low_q  <= ~s_q;
                duty_q       <= {8{s_q}};
                valid_q      <= 1'b1;
              end
            end
          end
          StMeasure: begin
            if (at_timeout) begin
              stuck_high_q <= s_q;
              stuck_low_q  <= ~s_q;
              duty_q       <= {8{s_q}};
              valid_q      <= 1'b1;
              per_cnt_q    <= '0;
              high_cnt_q   <= '0;
              state_q      <= StWaitRise;
            end else if (rise) begin
              high_time_q <= high_cnt_q;
              period_q    <= per_cnt_q;
              rem_q       <= {1'b0, high_cnt_q};
              quo_q       <= '0;
              step_q      <= '0;
              busy_q      <= 1'b1;
              per_cnt_q   <= CntOne;
              high_cnt_q  <= CntOne;
              state_q     <= StDivide;
            end else begin
              per_cnt_q  <= per_cnt_d;
              high_cnt_q <= high_cnt_d;
            end
          end
          StDivide: begin
            if (rise) begin
              // Period too short to divide: drop this measurement, keep counting the next.
              per_cnt_q  <= CntOne;
              high_cnt_q <= CntOne;
              overrun_q  <= 1'b1;
            end else begin
              per_cnt_q  <= per_cnt_d;
              high_cnt_q <= high_cnt_d;
            end
            rem_q  <= rem_d;
            quo_q  <= quo_d;
            step_q <= step_q + 3'd1;
            if (step_q == 3'd7) begin
              duty_q  <= quo_d;
              valid_q <= 1'b1;
              busy_q  <= 1'b0;
              state_q <= StMeasure;
            end
          end
          default: state_q <= StIdle;
        endcase
      end
    end
  end

  assign high_time  = high_time_q;
  assign period     = period_q;
  assign duty       = duty_q;
  assign valid      = valid_q;
  assign busy       = busy_q;
  assign stuck_high = stuck_high_q;
  assign stuck_low  = stuck_low_q;
  assign overrun    = overrun_q;

endmodule

// File: tb/tb_pwm_capture.sv
// tb_pwm_capture: directed, table-driven bench for pwm_capture with TIMEOUT=1000.
module tb_pwm_capture;

  localparam int unsigned CntW    = 16;
  localparam int unsigned Timeout = 1000;

  logic            clk = 1'b0;
  logic            rst;
  logic            enable;
  logic            pwm_in;
  logic [CntW-1:0] high_time;
  logic [CntW-1:0] period;
  logic [7:0]      duty;
  logic            valid;
  logic            busy;
  logic            stuck_high;
  logic            stuck_low;
  logic            overrun;

  pwm_capture #(
    .CNT_W  (CntW),
    .TIMEOUT(Timeout)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .enable    (enable),
    .pwm_in    (pwm_in),
    .high_time (high_time),
    .period    (period),
    .duty      (duty),
    .valid     (valid),
    .busy      (busy),
    .stuck_high(stuck_high),
    .stuck_low (stuck_low),
    .overrun   (overrun)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    int h;
    int l;
    int n;
    int ht;
    int per;
    int dty;
    int nv;
    int ovr;
  } vec_t;

  vec_t vecs [6];

  int checks        = 0;
  int errors        = 0;
  int neg_cnt       = 0;
  int last_rise_neg = 0;
  int nvalid        = 0;
  int v_neg         = 0;
  int v_lat         = 0;
  int busy_run      = 0;
  int v_busy_run    = 0;
  int rb_neg        = 0;

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // One cycle: sample outputs at the falling edge, then drive the next pwm_in value.
  task automatic tick(input logic p);
    @(negedge clk);
    neg_cnt++;
    if (busy) begin
      busy_run++;
    end else begin
      if (valid) begin
        nvalid++;
        v_neg      = neg_cnt;
        v_lat      = neg_cnt - last_rise_neg;
        v_busy_run = busy_run;
      end
      busy_run = 0;
    end
    if (p && !pwm_in) last_rise_neg = neg_cnt;
    pwm_in = p;
  endtask

  task automatic ticks(input int n, input logic p);
    for (int i = 0; i < n; i++) tick(p);
  endtask

  task automatic run_pwm(input int h, input int l, input int n);
    for (int k = 0; k < n; k++) begin
      ticks(h, 1'b1);
      ticks(l, 1'b0);
    end
  endtask

  task automatic restart();
    enable = 1'b0;
    ticks(3, 1'b0);
    enable = 1'b1;
    ticks(3, 1'b0);
  endtask

  task automatic check_zero(input string tag);
    check({tag, " high_time"}, int'(high_time), 0);
    check({tag, " period"}, int'(period), 0);
    check({tag, " duty"}, int'(duty), 0);
    check({tag, " valid"}, int'(valid), 0);
    check({tag, " busy"}, int'(busy), 0);
    check({tag, " stuck_high"}, int'(stuck_high), 0);
    check({tag, " stuck_low"}, int'(stuck_low), 0);
    check({tag, " overrun"}, int'(overrun), 0);
  endtask

  initial begin
    //         h    l    n  ht  per duty nv ovr
    vecs[0] = '{64, 192, 4, 64, 256, 64, 3, 0};
    vecs[1] = '{100, 200, 3, 100, 300, 85, 2, 0};
    vecs[2] = '{50, 50, 4, 50, 100, 128, 3, 0};
    vecs[3] = '{1, 9, 4, 1, 10, 25, 3, 0};
    vecs[4] = '{3, 4, 8, 3, 7, 109, 4, 1};
    vecs[5] = '{64, 192, 4, 64, 256, 64, 3, 1};

    rst    = 1'b1;
    enable = 1'b0;
    pwm_in = 1'b0;
    ticks(3, 1'b0);
    check_zero("reset");
    rst = 1'b0;

    for (int v = 0; v < 6; v++) begin
      restart();
      nvalid = 0;
      run_pwm(vecs[v].h, vecs[v].l, vecs[v].n);
      ticks(20, 1'b0);
      check($sformatf("v%0d valid_count", v), nvalid, vecs[v].nv);
      check($sformatf("v%0d high_time", v), int'(high_time), vecs[v].ht);
      check($sformatf("v%0d period", v), int'(period), vecs[v].per);
      check($sformatf("v%0d duty", v), int'(duty), vecs[v].dty);
      check($sformatf("v%0d latency", v), v_lat, 11);
      check($sformatf("v%0d busy_len", v), v_busy_run, 8);
      check($sformatf("v%0d overrun", v), int'(overrun), vecs[v].ovr);
      check($sformatf("v%0d stuck", v), int'(stuck_high | stuck_low), 0);
    end

    // Stuck high after one full 40/60 period, then recovery on a 50/50 pattern.
    restart();
    run_pwm(40, 60, 1);
    ticks(30, 1'b1);
    check("sh divide duty", int'(duty), 102);
    nvalid = 0;
    ticks(1070, 1'b1);
    check("sh stuck_high", int'(stuck_high), 1);
    check("sh stuck_low", int'(stuck_low), 0);
    check("sh duty", int'(duty), 255);
    check("sh valid_count", nvalid, 1);
    check("sh high_time hold", int'(high_time), 40);
    check("sh period hold", int'(period), 100);
    ticks(50, 1'b0);
    run_pwm(50, 50, 3);
    ticks(20, 1'b0);
    check("sh cleared", int'(stuck_high), 0);
    check("sh recover duty", int'(duty), 128);

    // Stuck low from enable; only one valid however long the line stays low.
    restart();
    nvalid = 0;
    ticks(1100, 1'b0);
    check("sl stuck_low", int'(stuck_low), 1);
    check("sl stuck_high", int'(stuck_high), 0);
    check("sl duty", int'(duty), 0);
    check("sl valid_count", nvalid, 1);
    check("sl period hold", int'(period), 100);
    ticks(1100, 1'b0);
    check("sl valid_count late", nvalid, 1);
    check("sl still stuck", int'(stuck_low), 1);

    // enable dropped during the divide: abort, no valid.
    restart();
    run_pwm(64, 192, 1);
    nvalid = 0;
    for (int i = 0; i < 256; i++) begin
      tick(i < 64);
      if (i == 4) enable = 1'b0;
      if (i == 5) begin
        check("en abort busy", int'(busy), 0);
        enable = 1'b1;
      end
    end
    ticks(20, 1'b0);
    check("en abort valid_count", nvalid, 0);

    // rst in the 4th divide cycle, then two fresh edges before the next result.
    restart();
    run_pwm(4, 252, 1);
    for (int i = 0; i < 256; i++) begin
      tick(i < 4);
      if (i == 6) begin
        check("rst busy before", int'(busy), 1);
        rst = 1'b1;
      end
      if (i == 7) begin
        check_zero("rst mid-divide");
        rst    = 1'b0;
        nvalid = 0;
      end
    end
    run_pwm(4, 252, 1);
    check("rst no early valid", nvalid, 0);
    tick(1'b1);
    rb_neg = neg_cnt;
    ticks(3, 1'b1);
    ticks(252, 1'b0);
    ticks(20, 1'b0);
    check("rst valid_count", nvalid, 1);
    check("rst valid timing", v_neg, rb_neg + 11);
    check("rst duty", int'(duty), 4);
    check("rst high_time", int'(high_time), 4);
    check("rst period", int'(period), 256);
    check("rst overrun", int'(overrun), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
